data_sramlike_responder: RTL and testbench

Slave end of the data sram-like protocol: accepts one request at a time from a sram-like initiator and performs it on a synchronous single-port data RAM. It returns `data_ok` after a programmable wait, so CPU-side sram-like bridges can be exercised against a realistic, non-zero-latency memory without an AXI fabric. It sits between the data sram-like bus and the block RAM.

---
 rtl/data_sramlike_responder.sv | 168 ++++++++++++++++
 tb/tb_data_sramlike_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sramlike_responder.sv
// -----------------------------------------------------------------------------
// data_sramlike_responder
//
// Slave end of a data sram-like bus in front of a synchronous single-port RAM.
// It accepts one request at a time, waits DELAY cycles, performs a single RAM
// access, then returns data_data_ok one cycle later. It models a memory with a
// realistic, non-zero latency for exercising sram-like initiators.
//
// Parameters:
//   ADDR_W : RAM word-address width (RAM depth 2^ADDR_W words, ADDR_W <= 30)
//   DELAY  : wait cycles between address handshake and RAM access (0..15)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   data_req/wr/size    request valid, 1 = write, 0 byte / 1 half / 2,3 word
//   data_addr/wdata     byte address, lane-positioned write data
//   data_addr_ok        address handshake (combinational from data_req in IDLE)
//   data_data_ok        one-cycle data handshake
//   data_rdata          read word, non-zero only with data_data_ok on a read
//   ram_en/wen          RAM enable and byte write enables (ACCESS only)
//   ram_addr/wdata      RAM word address and write data (latched request)
//   ram_rdata           RAM read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module data_sramlike_responder #(
   parameter int ADDR_W = 16,
   parameter int DELAY  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [3:0] DELAY_CNT = 4'(DELAY);
   // Byte-address bits kept: word address plus the two lane bits.
   localparam int         BADDR_W   = ADDR_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t               state_reg, state_next;
   logic [3:0]           cnt_reg, cnt_next;
   logic                 wr_reg;
   logic [1:0]           size_reg;
   logic [BADDR_W-1:0]   addr_reg;
   logic [31:0]          wdata_reg;
   logic                 accept;
   logic [3:0]           byte_mask;

   // Address bits above the RAM range are ignored, so out-of-range addresses
   // simply wrap onto the RAM.
   generate
      if (BADDR_W < 32) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^data_addr[31:BADDR_W];
      end
   endgenerate

   assign accept = data_addr_ok;

   // ---------------------------------------------------------------- state --
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Request latches: once accepted, the latched copy drives the access and
   // the bus inputs are no longer looked at until the next IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_reg    <= 1'b0;
         size_reg  <= 2'd0;
         addr_reg  <= '0;
         wdata_reg <= 32'd0;
      end else if (accept) begin
         wr_reg    <= data_wr;
         size_reg  <= data_size;
         addr_reg  <= data_addr[BADDR_W-1:0];
         wdata_reg <= data_wdata;
      end
   end

   // ----------------------------------------------------------- byte mask --
   always_comb begin
      byte_mask = 4'b1111;
      case (size_reg)
         2'd0:    byte_mask = 4'b0001 << addr_reg[1:0];
         2'd1:    byte_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   end

   // ---------------------------------------------- next state and outputs --
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'd0;
      ram_en       = 1'b0;
      ram_wen      = 4'b0000;

      case (state_reg)
         ST_IDLE: begin
            // Gated with rst_n so the handshake is low for the whole reset,
            // including the part of the cycle where reset asserts.
            data_addr_ok = data_req & rst_n;
            if (accept) begin
               if (DELAY > 0) begin
                  cnt_next   = DELAY_CNT;
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_ACCESS;
               end
            end
         end

         ST_WAIT: begin
            // Entered with the counter at DELAY, so leaving on 1 spends
            // exactly DELAY cycles here.
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               state_next = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            ram_en     = 1'b1;
            ram_wen    = wr_reg ? byte_mask : 4'b0000;
            state_next = ST_RESP;
         end

         ST_RESP: begin
            data_data_ok = 1'b1;
            data_rdata   = wr_reg ? 32'd0 : ram_rdata;
            state_next   = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ram_addr  = addr_reg[BADDR_W-1:2];
   assign ram_wdata = wdata_reg;

endmodule

// File: tb/tb_data_sramlike_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sramlike_responder
//
// Three responders share one request bus: instance 0 (DELAY=2) sits on a RAM
// model and carries the functional checks, instances 1 (DELAY=0) and
// 2 (DELAY=15) are used for latency checks on the first transaction after
// reset. Directed steps run in one initial block.
// -----------------------------------------------------------------------------
module tb_data_sramlike_responder;

   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic          addr_ok   [3];
   logic          data_ok   [3];
   logic [31:0]   rdata     [3];
   logic          ram_en    [3];
   logic [3:0]    ram_wen   [3];
   logic [AW-1:0] ram_addr  [3];
   logic [31:0]   ram_wdata [3];
   logic [31:0]   ram_rdata_m = 32'd0;

   logic [31:0] mem [2**AW];

   int cyc       = 0;
   int checks    = 0;
   int errors    = 0;
   int en_cnt    = 0;
   int dok_cnt   = 0;
   int both_cnt  = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         data_sramlike_responder #(
            .ADDR_W (AW),
            .DELAY  (gi == 0 ? 2 : (gi == 1 ? 0 : 15))
         ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .data_req     (req),
            .data_wr      (wr),
            .data_size    (size),
            .data_addr    (addr),
            .data_wdata   (wdata),
            .data_addr_ok (addr_ok[gi]),
            .data_data_ok (data_ok[gi]),
            .data_rdata   (rdata[gi]),
            .ram_en       (ram_en[gi]),
            .ram_wen      (ram_wen[gi]),
            .ram_addr     (ram_addr[gi]),
            .ram_wdata    (ram_wdata[gi]),
            .ram_rdata    (gi == 0 ? ram_rdata_m : 32'd0)
         );
      end
   endgenerate

   // Synchronous single-port RAM behind instance 0, registered read.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_en[0]) begin
         if (ram_wen[0] == 4'b0000) ram_rdata_m <= mem[ram_addr[0]];
         for (int b = 0; b < 4; b++) begin
            if (ram_wen[0][b]) mem[ram_addr[0]][b*8 +: 8] <= ram_wdata[0][b*8 +: 8];
         end
      end
   end

   // Pulse counters for instance 0, sampled mid-cycle.
   always @(negedge clk) begin
      #2;
      if (ram_en[0])                en_cnt   <= en_cnt + 1;
      if (data_ok[0])               dok_cnt  <= dok_cnt + 1;
      if (addr_ok[0] && data_ok[0]) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction on instance 0; latencies are relative to the handshake cycle.
   task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output int lat,
                      output int en_lat, output logic [3:0] wen_seen,
                      output logic [AW-1:0] addr_seen);
      int t0;
      bit hs;
      bit done;
      rd = 32'd0; lat = -1; en_lat = -1; wen_seen = 4'd0; addr_seen = '0;
      @(negedge clk);
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      hs = 1'b0; t0 = 0;
      for (int k = 0; k < 30 && !hs; k++) begin
         #1;
         if (addr_ok[0]) begin
            hs = 1'b1;
            t0 = cyc;
         end else begin
            @(negedge clk);
         end
      end
      chk("handshake_seen", 32'(hs), 32'd1);
      @(negedge clk);
      req = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         #1;
         if (ram_en[0] && en_lat < 0) begin
            en_lat    = cyc - t0;
            wen_seen  = ram_wen[0];
            addr_seen = ram_addr[0];
         end
         if (data_ok[0]) begin
            done = 1'b1;
            lat  = cyc - t0;
            rd   = rdata[0];
         end else begin
            @(negedge clk);
         end
      end
      $display("txn wr=%0d size=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h lat=%0d en_lat=%0d wen=%b",
               w, s, a, d, rd, lat, en_lat, wen_seen);
      chk("data_ok_seen", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   rd;
      int            lat, en_lat, t0, en_base, dok_base;
      int            hs_n, dok_n, last_hs, gap_bad, rd_bad;
      logic [3:0]    wen_s;
      logic [AW-1:0] addr_s;
      int            first [3];
      int            npulse [3];

      for (int i = 0; i < 2**AW; i++) mem[i] = 32'd0;

      // ---- reset with a request pending: everything quiet
      rst_n = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_addr_ok",   32'(addr_ok[0]),   32'd0);
      chk("rst_data_ok",   32'(data_ok[0]),   32'd0);
      chk("rst_rdata",     rdata[0],          32'd0);
      chk("rst_ram_en",    32'(ram_en[0]),    32'd0);
      chk("rst_ram_wen",   32'(ram_wen[0]),   32'd0);
      chk("rst_ram_addr",  32'(ram_addr[0]),  32'd0);
      chk("rst_ram_wdata", ram_wdata[0],      32'd0);

      // ---- release: handshake in first IDLE cycle; latency for DELAY 2/0/15
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_addr_ok", 32'(addr_ok[0]), 32'd1);
      t0 = cyc;
      for (int i = 0; i < 3; i++) begin first[i] = -1; npulse[i] = 0; end
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (k == 1) req = 1'b0;
         #1;
         for (int i = 0; i < 3; i++) begin
            if (data_ok[i]) begin
               npulse[i]++;
               if (first[i] < 0) first[i] = cyc - t0;
            end
         end
      end
      $display("latency d2=%0d d0=%0d d15=%0d pulses=%0d/%0d/%0d",
               first[0], first[1], first[2], npulse[0], npulse[1], npulse[2]);
      chk("lat_delay2",     32'(first[0]),  32'd4);
      chk("lat_delay0",     32'(first[1]),  32'd2);
      chk("lat_delay15",    32'(first[2]),  32'd17);
      chk("pulses_delay2",  32'(npulse[0]), 32'd1);
      chk("pulses_delay0",  32'(npulse[1]), 32'd1);
      chk("pulses_delay15", 32'(npulse[2]), 32'd1);

      // ---- word write then read, DELAY=2
      txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat, en_lat, wen_s, addr_s);
      chk("wr_en_lat",   32'(en_lat), 32'd3);
      chk("wr_wen",      32'(wen_s),  32'h0000000F);
      chk("wr_ram_addr", 32'(addr_s), 32'd4);
      chk("wr_lat",      32'(lat),    32'd4);
      chk("wr_rdata",    rd,          32'd0);
      txn(1'b0, 2'd2, 32'h10, 32'h0, rd, lat, en_lat, wen_s, addr_s);
      chk("rd_rdata", rd,          32'hDEADBEEF);
      chk("rd_wen",   32'(wen_s),  32'd0);
      chk("rd_lat",   32'(lat),    32'd4);

      // ---- partial writes onto a zeroed word
      txn(1'b1, 2'd2, 32'h10, 32'h00000000, rd, lat, en_lat, wen_s, addr_s);
      txn(1'b1, 2'd0, 32'h13, 32'hAAAAAAAA, rd, lat, en_lat, wen_s, addr_s);
      chk("byte13_wen",  32'(wen_s),  32'b1000);
      chk("byte13_addr", 32'(addr_s), 32'd4);
      txn(1'b1, 2'd1, 32'h12, 32'h55555555, rd, lat, en_lat, wen_s, addr_s);
      chk("half12_wen", 32'(wen_s), 32'b1100);
      txn(1'b1, 2'd1, 32'h11, 32'h00000000, rd, lat, en_lat, wen_s, addr_s);
      chk("half11_wen", 32'(wen_s), 32'b0011);
      txn(1'b0, 2'd2, 32'h10, 32'h0, rd, lat, en_lat, wen_s, addr_s);
      chk("partial_rdata", rd, 32'h55550000);
      // Upper address bits wrap onto the same word.
      txn(1'b0, 2'd3, 32'hF000_0410, 32'h0, rd, lat, en_lat, wen_s, addr_s);
      chk("wrap_rdata", rd, 32'h55550000);

      // ---- back-to-back with data_req held high
      @(negedge clk);
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
      hs_n = 0; dok_n = 0; last_hs = -1; gap_bad = 0; rd_bad = 0;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (addr_ok[0]) begin
            if (last_hs >= 0 && (cyc - last_hs) != 5) gap_bad++;
            last_hs = cyc;
            hs_n++;
         end
         if (data_ok[0]) begin
            dok_n++;
            if (rdata[0] !== 32'h55550000) rd_bad++;
         end
         @(negedge clk);
      end
      req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (data_ok[0]) begin
            dok_n++;
            if (rdata[0] !== 32'h55550000) rd_bad++;
         end
         @(negedge clk);
      end
      $display("back2back handshakes=%0d data_ok=%0d gap_errs=%0d rdata_errs=%0d", hs_n, dok_n, gap_bad, rd_bad);
      chk("b2b_handshakes", 32'(hs_n),    32'd6);
      chk("b2b_gap",        32'(gap_bad), 32'd0);
      chk("b2b_data_ok",    32'(dok_n),   32'd6);
      chk("b2b_rdata",      32'(rd_bad),  32'd0);

      // ---- reset while in WAIT abandons a write
      txn(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, rd, lat, en_lat, wen_s, addr_s);
      repeat (2) @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h12345678;
      #1;
      chk("wrst_handshake", 32'(addr_ok[0]), 32'd1);
      en_base  = en_cnt;
      dok_base = dok_cnt;
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("wrst_ram_addr",  32'(ram_addr[0]), 32'd0);
      chk("wrst_ram_wdata", ram_wdata[0],     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #3;
      $display("reset-in-wait ram_en pulses=%0d data_ok pulses=%0d", en_cnt - en_base, dok_cnt - dok_base);
      chk("wrst_no_ram_en",  32'(en_cnt - en_base),   32'd0);
      chk("wrst_no_data_ok", 32'(dok_cnt - dok_base), 32'd0);
      txn(1'b0, 2'd2, 32'h20, 32'h0, rd, lat, en_lat, wen_s, addr_s);
      chk("wrst_prior_value", rd, 32'hCAFEF00D);

      // ---- handshakes never overlap
      chk("never_both", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
